punc_loader: RTL and testbench
==============================

Name: punc_loader

Overview:
- Boot loader upstream of the PUnC core.
- Receives a byte stream over a valid/ready link, assembles big-endian 16-bit words and writes them into PUnC memory through the memory write port.
- Holds the core in reset (core reset is active-high) until the image is fully written, then releases it so the core's INIT state clears PC to 0 and begins fetching.
- Can be re-armed at run time to reload a new image.

Parameters:
- MEM_ADDR_W, 16, width of memory address output; the 16-bit load address is truncated to its low MEM_ADDR_W bits.
- MEM_DATA_W, 16, memory word width; fixed at 16, any other value is a configuration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- load_req  in  1  single-cycle request to reload; honoured only in RUN or ERR
- mem_wr  out  1  memory write strobe, one cycle per word
- mem_addr  out  MEM_ADDR_W  write address
- mem_data  out  16  write data
- cpu_rst  out  1  active-high reset to PUnC core
- done  out  1  image loaded, core running
- err  out  1  load failure; sticky until reload or rst

Behaviour:
- Transfer: a byte transfers on a rising clk edge with in_valid & in_ready.
- in_ready: combinational from state; 1 in header/data/checksum states, 0 in RUN and ERR.
- Stream format, all fields big-endian: ADDR[15:0], COUNT[15:0], then COUNT words of DATA (hi byte then lo byte).
- States: ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO -> DATA_HI <-> DATA_LO -> RUN; ERR is terminal until reload.
- ADDR_LO, CNT_LO: capture the low byte on transfer.
- After CNT_LO: COUNT==0 goes directly to RUN (no writes); otherwise go to DATA_HI.
- DATA_HI: latch high byte.
- DATA_LO transfer, following cycle:
  - mem_wr=1, mem_data={hi,lo}, mem_addr=current address.
  - Address then increments, wrapping 0xFFFF->0x0000 (modulo 2^MEM_ADDR_W after truncation).
  - Remaining count decrements; on reaching 0 go to RUN, else go to DATA_HI.
- Write latency: mem_wr asserts exactly 1 cycle after the lo-byte transfer. Minimum 2 cycles per word, so a write never overlaps the next word's lo byte.
- RUN: cpu_rst deasserts on the cycle after the last mem_wr (never the same cycle); done=1.
- load_req in RUN or ERR, next cycle: state ADDR_HI, cpu_rst=1, done=0, err=0.
- load_req in any loading state: ignored.
- in_valid without in_ready: no effect.
- Stalls: in_valid low for any number of cycles mid-stream; state holds indefinitely. No timeout.
- Reset (rst=0) at any time, including mid-word, next cycle:
  - state ADDR_HI, cpu_rst=1, mem_wr=0, mem_addr=0, mem_data=0, done=0, err=0.
  - Partial word discarded; pending mem_wr suppressed.
- Outputs mem_wr, mem_addr, mem_data, cpu_rst, done, err are registered.

Optional Feature:
- Macro: PUNC_LOADER_CHECKSUM_EN.
- Defined: after the last DATA word, two more bytes CSUM_HI and CSUM_LO carry a 16-bit checksum.
  - Expected value is the mod-2^16 sum of all DATA words.
  - COUNT==0 still requires the checksum (expected 0x0000).
  - Match -> RUN.
  - Mismatch -> ERR: err=1, cpu_rst stays 1, already-written memory is not rolled back.
- Undefined: no checksum states; err is tied 0; ERR is unreachable.

Decomposition:
- Shared package/defines file holds:
  - state encoding localparams (LDR_ADDR_HI … LDR_ERR);
  - stream field byte order;
  - checksum width.
- One sub-module, punc_loader_word_asm: byte-pair to 16-bit word assembler with hi latch and 1-cycle registered write strobe.
- FSM, address counter and word counter stay in the top.

Test Plan:
- Stream 00 10 00 02 12 34 AB CD -> mem_wr at addr 0x0010 data 0x1234, then addr 0x0011 data 0xABCD; cpu_rst falls the cycle after the second write; done=1; in_ready=0.
- Stream 00 05 00 00 -> no mem_wr; RUN reached 1 cycle after the last byte; cpu_rst=0.
- ADDR=FFFF, COUNT=2, data 0001 0002 -> writes at 0xFFFF then 0x0000; repeat with MEM_ADDR_W=8: writes at 0xFF then 0x00.
- Random in_valid gaps of 0-5 cycles on the first stream -> identical write sequence and values; no extra mem_wr.
- rst=0 for 1 cycle after the DATA_HI byte of word 1, then a fresh stream 00 20 00 01 BE EF -> only write is addr 0x0020 data 0xBEEF.
- With PUNC_LOADER_CHECKSUM_EN:
  - data 1234 ABCD, checksum BE01 -> done=1.
  - checksum BE02 -> err=1, cpu_rst stays 1.
  - then load_req -> err=0, in_ready=1, and a reload succeeds.

Source files
------------

// File: rtl/punc_loader_pkg.sv
// Shared definitions for the PUnC boot loader: FSM state encoding, stream byte order, checksum width.
// Optional checksum trailer is enabled with PUNC_LOADER_CHECKSUM_EN.
package punc_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int CSUM_W = 16;

    // Every multi-byte stream field (ADDR, COUNT, DATA, CSUM) arrives high byte first.
    localparam bit HI_BYTE_FIRST = 1'b1;

    typedef enum logic [3:0] {
        LDR_ADDR_HI = 4'd0,
        LDR_ADDR_LO = 4'd1,
        LDR_CNT_HI  = 4'd2,
        LDR_CNT_LO  = 4'd3,
        LDR_DATA_HI = 4'd4,
        LDR_DATA_LO = 4'd5,
        LDR_CSUM_HI = 4'd6,
        LDR_CSUM_LO = 4'd7,
        LDR_RUN     = 4'd8,
        LDR_ERR     = 4'd9
    } ldr_state_t;

    function automatic logic [WORD_W-1:0] be_word(input logic [BYTE_W-1:0] first,
                                                  input logic [BYTE_W-1:0] second);
        return HI_BYTE_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/punc_loader_word_asm.sv
// Purpose: pairs stream bytes into one 16-bit memory word and issues its write.
// Latency: write strobe, address and data registered 1 cycle after the low-byte transfer.
// Backpressure: none; the parent only pulses hi_en/lo_en on accepted bytes.
module punc_loader_word_asm
    import punc_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data
);

    logic [BYTE_W-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q    <= '0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr <= lo_en;
            if (hi_en) begin
                hi_q <= in_byte;
            end
            if (lo_en) begin
                wr_addr <= addr;
                wr_data <= be_word(hi_q, in_byte);
            end
        end
    end

endmodule

// File: rtl/punc_loader.sv
// Purpose: boot loader; parses ADDR/COUNT/DATA byte stream into PUnC memory writes, holds core in reset until done.
// Latency: memory write 1 cycle after each low data byte; cpu_rst drops the cycle after the last write.
// Backpressure: in_ready low in RUN/ERR only; stream may stall indefinitely. Checksum trailer: PUNC_LOADER_CHECKSUM_EN.
module punc_loader
    import punc_loader_pkg::*;
#(
    parameter int MEM_ADDR_W = 16,
    parameter int MEM_DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  load_req,
    output logic                  mem_wr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    if (MEM_DATA_W != WORD_W) begin : g_bad_data_w
        $error("punc_loader: MEM_DATA_W must be 16");
    end
    if (MEM_ADDR_W < 1 || MEM_ADDR_W > 16) begin : g_bad_addr_w
        $error("punc_loader: MEM_ADDR_W must be 1..16");
    end

`ifdef PUNC_LOADER_CHECKSUM_EN
    localparam ldr_state_t LDR_AFTER_DATA = LDR_CSUM_HI;
`else
    localparam ldr_state_t LDR_AFTER_DATA = LDR_RUN;
`endif

    ldr_state_t  state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] cnt_q;
    logic        xfer;

    assign in_ready = (state_q != LDR_RUN) && (state_q != LDR_ERR);
    assign xfer     = in_valid && in_ready;

`ifdef PUNC_LOADER_CHECKSUM_EN
    logic [7:0]        csum_hi_q;
    logic [CSUM_W-1:0] sum_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LDR_ADDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_ADDR_HI: if (xfer) state_d = LDR_ADDR_LO;
            LDR_ADDR_LO: if (xfer) state_d = LDR_CNT_HI;
            LDR_CNT_HI:  if (xfer) state_d = LDR_CNT_LO;
            LDR_CNT_LO: begin
                if (xfer) begin
                    state_d = ({cnt_q[15:8], in_data} == 16'd0) ? LDR_AFTER_DATA : LDR_DATA_HI;
                end
            end
            LDR_DATA_HI: if (xfer) state_d = LDR_DATA_LO;
            LDR_DATA_LO: begin
                if (xfer) begin
                    state_d = (cnt_q == 16'd1) ? LDR_AFTER_DATA : LDR_DATA_HI;
                end
            end
`ifdef PUNC_LOADER_CHECKSUM_EN
            LDR_CSUM_HI: if (xfer) state_d = LDR_CSUM_LO;
            LDR_CSUM_LO: begin
                if (xfer) begin
                    state_d = (be_word(csum_hi_q, in_data) == sum_q) ? LDR_RUN : LDR_ERR;
                end
            end
`endif
            LDR_RUN, LDR_ERR: if (load_req) state_d = LDR_ADDR_HI;
            default: state_d = LDR_ADDR_HI;
        endcase
    end

    // Address wraps at 16 bits; only the low MEM_ADDR_W bits reach memory, so it also wraps there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (xfer) begin
            case (state_q)
                LDR_ADDR_HI: addr_q[15:8] <= in_data;
                LDR_ADDR_LO: addr_q[7:0]  <= in_data;
                LDR_CNT_HI:  cnt_q[15:8]  <= in_data;
                LDR_CNT_LO:  cnt_q[7:0]   <= in_data;
                LDR_DATA_LO: begin
                    addr_q <= addr_q + 16'd1;
                    cnt_q  <= cnt_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    punc_loader_word_asm #(
        .ADDR_W (MEM_ADDR_W)
    ) u_word_asm (
        .clk     (clk),
        .rst     (rst),
        .hi_en   (xfer && (state_q == LDR_DATA_HI)),
        .lo_en   (xfer && (state_q == LDR_DATA_LO)),
        .in_byte (in_data),
        .addr    (addr_q[MEM_ADDR_W-1:0]),
        .wr      (mem_wr),
        .wr_addr (mem_addr),
        .wr_data (mem_data)
    );

    // Qualifying with state_d keeps RUN outputs off during the write cycle and drops them
    // the cycle after a reload request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
        end else begin
            cpu_rst <= !((state_q == LDR_RUN) && (state_d == LDR_RUN));
            done    <= (state_q == LDR_RUN) && (state_d == LDR_RUN);
        end
    end

`ifdef PUNC_LOADER_CHECKSUM_EN
    // Summing the written words: the last word's write lands before CSUM_LO can transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_hi_q <= '0;
            sum_q     <= '0;
            err       <= 1'b0;
        end else begin
            err <= (state_q == LDR_ERR) && (state_d == LDR_ERR);
            if (xfer && (state_q == LDR_CSUM_HI)) begin
                csum_hi_q <= in_data;
            end
            if (xfer && (state_q == LDR_ADDR_HI)) begin
                sum_q <= '0;
            end else if (mem_wr) begin
                sum_q <= sum_q + mem_data;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_punc_loader.sv
// Self-checking bench for punc_loader: random-gap byte streams against a stream-level reference model,
// on a 16-bit and an 8-bit address instance driven in parallel.
module tb_punc_loader;

`ifdef PUNC_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        load_req;
    logic        in_ready, mem_wr, cpu_rst, done, err;
    logic [15:0] mem_addr, mem_data;
    logic        in_ready8, mem_wr8, cpu_rst8, done8, err8;
    logic [7:0]  mem_addr8;
    logic [15:0] mem_data8;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int last_wr_cyc = -1;
    int last_xfer = -1;
    logic prev_cpu_rst = 1'b1;

    logic [7:0] stream[$];
    int exp_a[$], exp_d[$];
    bit exp_ok;
    int got_a[$], got_d[$], got_a8[$], got_d8[$];

    punc_loader #(.MEM_ADDR_W(16), .MEM_DATA_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_req(load_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    punc_loader #(.MEM_ADDR_W(8), .MEM_DATA_W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
        .load_req(load_req), .mem_wr(mem_wr8), .mem_addr(mem_addr8), .mem_data(mem_data8),
        .cpu_rst(cpu_rst8), .done(done8), .err(err8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr) begin
            got_a.push_back(int'(mem_addr));
            got_d.push_back(int'(mem_data));
            last_wr_cyc = cyc;
        end
        if (mem_wr8) begin
            got_a8.push_back(int'(mem_addr8));
            got_d8.push_back(int'(mem_data8));
        end
        if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
    end

    // Reference: parse the whole image from the byte list.
    function automatic void model();
        int a, n, w, sum, c;
        a = stream[0] * 256 + stream[1];
        n = stream[2] * 256 + stream[3];
        sum = 0;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < n; i++) begin
            w = stream[4 + 2 * i] * 256 + stream[5 + 2 * i];
            exp_a.push_back((a + i) % 65536);
            exp_d.push_back(w);
            sum = (sum + w) % 65536;
        end
        exp_ok = 1'b1;
        if (CSUM_ON) begin
            c = stream[4 + 2 * n] * 256 + stream[5 + 2 * n];
            exp_ok = (c == sum);
        end
    endfunction

    function automatic void add_csum(input bit good);
        int n, sum;
        if (CSUM_ON) begin
            n = stream[2] * 256 + stream[3];
            sum = 0;
            for (int i = 0; i < n; i++) sum += stream[4 + 2 * i] * 256 + stream[5 + 2 * i];
            if (!good) sum += 1;
            sum = sum % 65536;
            stream.push_back(8'(sum / 256));
            stream.push_back(8'(sum % 256));
        end
    endfunction

    function automatic void clear_capture();
        got_a.delete(); got_d.delete(); got_a8.delete(); got_d8.delete();
        fall_cyc = -1;
        last_wr_cyc = -1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            load_req = noise && (g == 0) && ($urandom_range(1, 0) == 1);
            @(negedge clk);
        end
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept: in_ready stuck at %0b, want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_xfer = cyc;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_stream(input int max_gap, input bit noise);
        foreach (stream[i]) send_byte(stream[i], $urandom_range(max_gap, 0), noise);
    endtask

    task automatic check_result(input string name);
        bit exp_err;
        repeat (4) @(negedge clk);
        #1;
        exp_err = CSUM_ON && !exp_ok;
        vectors++;
        if (got_a.size() !== exp_a.size()) begin
            miscompares++;
            $display("FAIL %s wr_count: got %0d want %0d", name, got_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            vectors++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL %s wr[%0d]: got %h/%h want %h/%h", name, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
        end
        vectors++;
        if (got_a8.size() !== exp_a.size()) begin
            miscompares++;
            $display("FAIL %s wr8_count: got %0d want %0d", name, got_a8.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a8.size(); i++) begin
            vectors++;
            if (got_a8[i] !== (exp_a[i] % 256) || got_d8[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL %s wr8[%0d]: got %h/%h want %h/%h", name, i, got_a8[i], got_d8[i], exp_a[i] % 256, exp_d[i]);
            end
        end
        vectors++;
        if (done !== exp_ok || done8 !== exp_ok) begin
            miscompares++;
            $display("FAIL %s done: got %b/%b want %b", name, done, done8, exp_ok);
        end
        vectors++;
        if (cpu_rst !== !exp_ok) begin
            miscompares++;
            $display("FAIL %s cpu_rst: got %b want %b", name, cpu_rst, !exp_ok);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s in_ready: got %b want 0", name, in_ready);
        end
        vectors++;
        if (fall_cyc !== (exp_ok ? last_xfer + 1 : -1)) begin
            miscompares++;
            $display("FAIL %s cpu_rst_fall: got cycle %0d want %0d", name, fall_cyc, exp_ok ? last_xfer + 1 : -1);
        end
        if (exp_ok && exp_a.size() > 0) begin
            vectors++;
            if (fall_cyc <= last_wr_cyc) begin
                miscompares++;
                $display("FAIL %s rst_vs_wr: cpu_rst fell at %0d, last write at %0d", name, fall_cyc, last_wr_cyc);
            end
        end
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s reload: cpu_rst=%b done=%b err=%b in_ready=%b want 1 0 0 1",
                     name, cpu_rst, done, err, in_ready);
        end
    endtask

    task automatic check_reset_state(input string name);
        vectors++;
        if (cpu_rst !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_data !== 16'h0 ||
            done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || mem_addr8 !== 8'h0) begin
            miscompares++;
            $display("FAIL %s: cpu_rst=%b mem_wr=%b addr=%h data=%h done=%b err=%b rdy=%b, want 1 0 0000 0000 0 0 1",
                     name, cpu_rst, mem_wr, mem_addr, mem_data, done, err, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset_state");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n_before;
        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_csum(1'b1);
        model();
        clear_capture();
        send_stream(0, 1'b0);
        check_result("basic");
        // Valid bytes offered while running must be ignored.
        n_before = got_a.size();
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (got_a.size() !== n_before || done !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_valid: writes %0d done %b, want %0d 1", got_a.size(), done, n_before);
        end
        do_reload("basic");
    endtask

    task automatic test_zero_count();
        stream = '{8'h00, 8'h05, 8'h00, 8'h00};
        add_csum(1'b1);
        model();
        clear_capture();
        send_stream(0, 1'b0);
        check_result("zero_count");
        do_reload("zero_count");
    endtask

    task automatic test_wrap();
        stream = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        add_csum(1'b1);
        model();
        clear_capture();
        send_stream(0, 1'b0);
        check_result("wrap");
        do_reload("wrap");
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
            add_csum(1'b1);
            model();
            clear_capture();
            send_stream(5, 1'b0);
            check_result("gaps");
            do_reload("gaps");
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 5; r++) begin
            stream.delete();
            n = $urandom_range(6, 0);
            stream.push_back(8'($urandom));
            stream.push_back(8'($urandom));
            stream.push_back(8'(n / 256));
            stream.push_back(8'(n % 256));
            for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
            add_csum($urandom_range(3, 0) != 0);
            model();
            clear_capture();
            send_stream(3, 1'b1);
            check_result("random");
            do_reload("random");
        end
    endtask

    task automatic test_reset_midword();
        clear_capture();
        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
        send_stream(0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset_midword_state");
        stream = '{8'h00, 8'h20, 8'h00, 8'h01, 8'hBE, 8'hEF};
        add_csum(1'b1);
        model();
        send_stream(0, 1'b0);
        check_result("reset_midword");
        do_reload("reset_midword");
    endtask

`ifdef PUNC_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
        model();
        clear_capture();
        send_stream(0, 1'b0);
        check_result("csum_bad");
        do_reload("csum_bad");
        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        model();
        clear_capture();
        send_stream(2, 1'b0);
        check_result("csum_good");
        do_reload("csum_good");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_gaps();
        test_random();
        test_reset_midword();
`ifdef PUNC_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
